// File: rtl/io_circuits_pkg.sv
// Shared constants and width helpers for the I/O conditioning blocks.
package io_circuits_pkg;

  localparam int unsigned SAMPLE_CNT_MAX_DEFAULT = 62500;  // 0.5 ms tick at 125 MHz
  localparam int unsigned PULSE_CNT_MAX_DEFAULT  = 200;
  localparam int unsigned SYNC_STAGES_MIN        = 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // A counter over a single state still needs one physical bit.
  function automatic int unsigned cnt_width(input int unsigned value);
    return (clog2(value) > 0) ? clog2(value) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: saturating sample counter, registered level and edge pulses.
// The fall output exists only when INPUT_CONDITIONER_FALL_EN is defined.
module debounce_channel
  import io_circuits_pkg::*;
#(
  parameter int unsigned PULSE_CNT_MAX = PULSE_CNT_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sync_in,
  output logic level,
  output logic rise
`ifdef INPUT_CONDITIONER_FALL_EN
  ,
  output logic fall
`endif
);

  localparam int unsigned CW = cnt_width(PULSE_CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(PULSE_CNT_MAX);

  logic [CW-1:0] cnt;
  logic          level_d;

  // Any low sample restarts the count immediately, independent of the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      level_d <= 1'b0;
    end else begin
      level_d <= level;
      if (!sync_in)
        cnt <= '0;
      else if (tick && (cnt < CNT_MAX))
        cnt <= cnt + 1'b1;
    end
  end

  assign level = (cnt == CNT_MAX);
  assign rise  = level & ~level_d;
`ifdef INPUT_CONDITIONER_FALL_EN
  assign fall  = ~level & level_d;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel synchronizer + debouncer with a shared sample timer.
// Optional fall pulses are compiled in with INPUT_CONDITIONER_FALL_EN.
module input_conditioner
  import io_circuits_pkg::*;
#(
  parameter int unsigned WIDTH          = 1,
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_MIN,
  parameter int unsigned SAMPLE_CNT_MAX = SAMPLE_CNT_MAX_DEFAULT,
  parameter int unsigned PULSE_CNT_MAX  = PULSE_CNT_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
`ifdef INPUT_CONDITIONER_FALL_EN
  ,
  output logic [WIDTH-1:0] fall
`endif
);

  localparam int unsigned TW = cnt_width(SAMPLE_CNT_MAX);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_CNT_MAX - 1);

  logic [WIDTH-1:0][SYNC_STAGES-1:0] chain;
  logic [TW-1:0]                     timer;
  logic                              tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++)
        chain[i] <= {chain[i][SYNC_STAGES-2:0], async_in[i]};
    end
  end

  always_comb begin
    sync_out = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      sync_out[i] = chain[i][SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst)
      timer <= '0;
    else if (tick)
      timer <= '0;
    else
      timer <= timer + 1'b1;
  end

  assign tick = (timer == TIMER_LAST);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_channel #(
      .PULSE_CNT_MAX(PULSE_CNT_MAX)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .sync_in (sync_out[g]),
      .level   (level[g]),
      .rise    (rise[g])
`ifdef INPUT_CONDITIONER_FALL_EN
      ,
      .fall    (fall[g])
`endif
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner (2-channel main DUT plus a
// single-channel instance with unit tick and unit pulse count).
module tb_input_conditioner;

  logic       clk;
  logic       rst;
  logic [1:0] async_in;
  logic [1:0] sync_out;
  logic [1:0] level;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       f_in;
  logic       f_sync;
  logic       f_level;
  logic       f_rise;
  logic       f_fall;

  int total;
  int bad;

  input_conditioner #(
    .WIDTH(2), .SYNC_STAGES(2), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3)
  ) dut (
    .clk(clk), .rst(rst), .async_in(async_in), .sync_out(sync_out),
    .level(level), .rise(rise)
`ifdef INPUT_CONDITIONER_FALL_EN
    , .fall(fall)
`endif
  );

  input_conditioner #(
    .WIDTH(1), .SYNC_STAGES(2), .SAMPLE_CNT_MAX(1), .PULSE_CNT_MAX(1)
  ) u_fast (
    .clk(clk), .rst(rst), .async_in(f_in), .sync_out(f_sync),
    .level(f_level), .rise(f_rise)
`ifdef INPUT_CONDITIONER_FALL_EN
    , .fall(f_fall)
`endif
  );

`ifndef INPUT_CONDITIONER_FALL_EN
  assign fall   = 2'b00;
  assign f_fall = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; async_in = 2'b11; f_in = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      total++;
      if ({sync_out, level, rise} !== 6'b0) begin
        bad++; $display("FAIL reset_outs e=%0d: got %b want 000000", e, {sync_out, level, rise});
      end
`ifdef INPUT_CONDITIONER_FALL_EN
      total++;
      if (fall !== 2'b00) begin
        bad++; $display("FAIL reset_fall e=%0d: got %b want 00", e, fall);
      end
`endif
    end
    rst = 1'b0;
    step();
    total++;
    if (sync_out !== 2'b00) begin
      bad++; $display("FAIL sync_lat1: got %b want 00", sync_out);
    end
    step();
    total++;
    if (sync_out !== 2'b11) begin
      bad++; $display("FAIL sync_lat2: got %b want 11", sync_out);
    end
    // timer restarted at 0: ticks fall on edges 4, 8, 12 after release
    for (int e = 3; e <= 12; e++) begin
      step();
      total++;
      if (level !== ((e == 12) ? 2'b11 : 2'b00)) begin
        bad++; $display("FAIL post_reset_level e=%0d: got %b want %b", e, level, (e == 12) ? 2'b11 : 2'b00);
      end
      total++;
      if (rise !== ((e == 12) ? 2'b11 : 2'b00)) begin
        bad++; $display("FAIL post_reset_rise e=%0d: got %b want %b", e, rise, (e == 12) ? 2'b11 : 2'b00);
      end
    end
    async_in = 2'b00;
    repeat (3) step();
    total++;
    if (level !== 2'b00) begin
      bad++; $display("FAIL post_reset_drop: got %b want 00", level);
    end
    repeat (2) step();
  endtask

  task automatic test_press();
    int first;
    int rises;
    int ch1_bad;
    first = 0; rises = 0; ch1_bad = 0;
    async_in = 2'b01;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (level[0] && first == 0) first = e;
      if (rise[0]) rises++;
      if (level[1] || rise[1] || sync_out[1]) ch1_bad++;
    end
    total++;
    if (first < 11 || first > 14) begin
      bad++; $display("FAIL press_latency: got %0d want 11..14", first);
    end
    total++;
    if (rises != 1) begin
      bad++; $display("FAIL press_rise_count: got %0d want 1", rises);
    end
    total++;
    if (ch1_bad != 0) begin
      bad++; $display("FAIL press_ch1_quiet: got %0d active cycles want 0", ch1_bad);
    end
  endtask

  task automatic test_release();
    async_in = 2'b00;
    for (int e = 1; e <= 4; e++) begin
      step();
      total++;
      if (level[0] !== (e < 3)) begin
        bad++; $display("FAIL release_level e=%0d: got %b want %b", e, level[0], (e < 3));
      end
      total++;
      if (rise[0] !== 1'b0) begin
        bad++; $display("FAIL release_rise e=%0d: got %b want 0", e, rise[0]);
      end
`ifdef INPUT_CONDITIONER_FALL_EN
      total++;
      if (fall[0] !== (e == 3)) begin
        bad++; $display("FAIL release_fall e=%0d: got %b want %b", e, fall[0], (e == 3));
      end
`endif
    end
  endtask

  task automatic test_bounce();
    int noisy;
    int first;
    int rises;
    noisy = 0; first = 0; rises = 0;
    for (int k = 0; k < 4; k++) begin
      async_in = {1'b0, (k % 2 == 0)};
      repeat (3) begin
        step();
        if (level[0] || rise[0]) noisy++;
      end
    end
    total++;
    if (noisy != 0) begin
      bad++; $display("FAIL bounce_quiet: got %0d active cycles want 0", noisy);
    end
    async_in = 2'b01;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (level[0] && first == 0) first = e;
      if (rise[0]) rises++;
    end
    total++;
    if (first < 11 || first > 14) begin
      bad++; $display("FAIL bounce_latency: got %0d want 11..14", first);
    end
    total++;
    if (rises != 1) begin
      bad++; $display("FAIL bounce_rise_count: got %0d want 1", rises);
    end
  endtask

  task automatic test_reset_mid();
    async_in = 2'b01;
    rst = 1'b1; step(); rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      total++;
      if (level !== 2'b00) begin
        bad++; $display("FAIL mid_pre_level e=%0d: got %b want 00", e, level);
      end
    end
    // count is 2 here; reset must restart it from zero
    rst = 1'b1; step(); rst = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      step();
      total++;
      if (level !== {1'b0, e >= 12}) begin
        bad++; $display("FAIL mid_restart_level e=%0d: got %b want %b", e, level, {1'b0, e >= 12});
      end
      total++;
      if (rise !== {1'b0, e == 12}) begin
        bad++; $display("FAIL mid_restart_rise e=%0d: got %b want %b", e, rise, {1'b0, e == 12});
      end
    end
    rst = 1'b1; step(); rst = 1'b0;
    total++;
    if ({level, rise, fall} !== 6'b0) begin
      bad++; $display("FAIL high_reset_outs: got %b want 000000", {level, rise, fall});
    end
    for (int e = 1; e <= 3; e++) begin
      step();
      total++;
      if ({level, fall} !== 4'b0) begin
        bad++; $display("FAIL high_reset_nofall e=%0d: got %b want 0000", e, {level, fall});
      end
    end
  endtask

  task automatic test_fast();
    f_in = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      total++;
      if (f_level !== (e >= 3)) begin
        bad++; $display("FAIL fast_level e=%0d: got %b want %b", e, f_level, (e >= 3));
      end
      total++;
      if (f_rise !== (e == 3)) begin
        bad++; $display("FAIL fast_rise e=%0d: got %b want %b", e, f_rise, (e == 3));
      end
    end
    f_in = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      total++;
      if (f_level !== (e < 3)) begin
        bad++; $display("FAIL fast_drop e=%0d: got %b want %b", e, f_level, (e < 3));
      end
`ifdef INPUT_CONDITIONER_FALL_EN
      total++;
      if (f_fall !== (e == 3)) begin
        bad++; $display("FAIL fast_fall e=%0d: got %b want %b", e, f_fall, (e == 3));
      end
`endif
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; async_in = 2'b00; f_in = 1'b0;
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_reset_mid();
    test_fast();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
